ram_host_adapter: RTL and testbench

Host-bus front end for one port of the dual-port RAM: accepts req/ack transactions with byte address and byte enables and converts them to the RAM's word-addressed, one-cycle-read-latency, full-word-write port. Partial-byte writes become an internal read-modify-write. One adapter instance sits directly upstream of each RAM port, e.g. instruction side on port 0 and data side on port 1. One transaction is outstanding at a time.

---
 rtl/ram_host_adapter.sv | 193 +++++++++++++++++++
 tb/tb_ram_host_adapter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_host_adapter.sv
// ram_host_adapter
// Host req/ack front end for one port of the dual-port RAM. Converts byte
// addressed host transactions with byte enables into the RAM's word
// addressed, one-cycle-read-latency, full-word-write port. Partial-byte
// writes are carried out as an internal read-modify-write.
//
// Optional feature macro: RAM_HOST_ADAPTER_RANGECHK_EN
//   defined   : accesses with word address >= mem_size are acked but never
//               write the RAM; such reads return zero.
//   undefined : the word address wraps modulo mem_size.

module ram_host_adapter #(
    parameter int dat_width = 32,
    parameter int adr_width = 32,
    parameter int mem_size  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_req,
    output logic                   host_ack,
    input  logic                   host_we,
    input  logic [adr_width-1:0]   host_addr,
    input  logic [dat_width/8-1:0] host_be,
    input  logic [dat_width-1:0]   host_wdata,
    output logic                   host_resp,
    output logic [dat_width-1:0]   host_rdata,
    output logic [adr_width-1:0]   ram_adr_o,
    output logic [dat_width-1:0]   ram_dat_o,
    output logic                   ram_we_o,
    input  logic [dat_width-1:0]   ram_dat_i
);

    localparam int BE_W  = dat_width / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW     = 2'd2
    } state_t;

    // Byte-lane merge: lanes with an enable come from the new word,
    // the remaining lanes keep the word read back from the RAM.
    function automatic logic [dat_width-1:0] merge_bytes(
        input logic [dat_width-1:0] new_word,
        input logic [dat_width-1:0] old_word,
        input logic [BE_W-1:0]      be
    );
        logic [dat_width-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Registered state
    state_t               state_q, state_d;
    logic [adr_width-1:0] adr_q, adr_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [dat_width-1:0] wdata_q, wdata_d;
    logic                 resp_q, resp_d;
    logic [dat_width-1:0] rdata_q, rdata_d;
    logic                 oor_q, oor_d;

    // Combinational helpers
    logic [adr_width-1:0] wadr_s;
    logic [adr_width-1:0] ram_wadr_s;
    logic                 oor_s;
    logic                 ack_s;
    logic                 be_all_s;
    logic                 be_none_s;
    logic [adr_width-1:0] ram_adr_s;
    logic [dat_width-1:0] ram_dat_s;
    logic                 ram_we_s;

    assign wadr_s    = host_addr >> OFF_W;
    assign be_all_s  = &host_be;
    assign be_none_s = ~|host_be;

`ifdef RAM_HOST_ADAPTER_RANGECHK_EN
    localparam logic [adr_width-1:0] MEM_LIMIT = adr_width'(mem_size);

    // Full word address goes to the RAM; out-of-range accesses are flagged.
    assign ram_wadr_s = wadr_s;
    assign oor_s      = (wadr_s >= MEM_LIMIT);
`else
    localparam logic [adr_width-1:0] WADR_MASK = adr_width'(mem_size - 1);

    // Word address wraps onto the RAM depth; nothing is ever out of range.
    assign ram_wadr_s = wadr_s & WADR_MASK;
    assign oor_s      = 1'b0;
`endif

    // Ack only from IDLE and never while reset is held.
    assign ack_s = host_req & (state_q == IDLE) & ~rst;

    // Next-state, latch and RAM-port control for all three states.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        resp_d    = 1'b0;
        rdata_d   = rdata_q;
        oor_d     = oor_q;
        ram_adr_s = adr_q;
        ram_dat_s = wdata_q;
        ram_we_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ack_s) begin
                    if (!host_we) begin
                        // Read: present the address now, data comes back next cycle.
                        adr_d     = ram_wadr_s;
                        oor_d     = oor_s;
                        ram_adr_s = ram_wadr_s;
                        state_d   = RD_WAIT;
                    end else if (be_none_s) begin
                        // Empty write: acked, nothing to do.
                        state_d = IDLE;
                    end else if (be_all_s) begin
                        // Full-word write goes straight through in the ack cycle.
                        ram_adr_s = ram_wadr_s;
                        ram_dat_s = host_wdata;
                        ram_we_s  = ~oor_s;
                        state_d   = IDLE;
                    end else if (oor_s) begin
                        // Out-of-range partial write is dropped without RMW.
                        state_d = IDLE;
                    end else begin
                        // Partial write: read the old word, merge next cycle.
                        adr_d     = ram_wadr_s;
                        be_d      = host_be;
                        wdata_d   = host_wdata;
                        ram_adr_s = ram_wadr_s;
                        state_d   = RMW;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                resp_d  = 1'b1;
                rdata_d = oor_q ? {dat_width{1'b0}} : ram_dat_i;
                state_d = IDLE;
            end
            RMW: begin
                ram_we_s  = 1'b1;
                ram_dat_s = merge_bytes(wdata_q, ram_dat_i, be_q);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= {adr_width{1'b0}};
            be_q    <= {BE_W{1'b0}};
            wdata_q <= {dat_width{1'b0}};
            resp_q  <= 1'b0;
            rdata_q <= {dat_width{1'b0}};
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    assign host_ack   = ack_s;
    assign host_resp  = resp_q;
    assign host_rdata = rdata_q;
    assign ram_adr_o  = ram_adr_s;
    assign ram_dat_o  = ram_dat_s;
    // Reset overrides any pending write, including the RMW write-back.
    assign ram_we_o   = ram_we_s & ~rst;

endmodule

// File: tb/tb_ram_host_adapter.sv
// Directed self-checking bench for ram_host_adapter with a behavioural
// one-cycle-latency RAM model attached to the RAM port.

module tb_ram_host_adapter;

    logic        clk;
    logic        rst;
    logic        host_req;
    logic        host_ack;
    logic        host_we;
    logic [31:0] host_addr;
    logic [3:0]  host_be;
    logic [31:0] host_wdata;
    logic        host_resp;
    logic [31:0] host_rdata;
    logic [31:0] ram_adr_o;
    logic [31:0] ram_dat_o;
    logic        ram_we_o;
    logic [31:0] ram_dat_i;

    logic        pre_we;
    logic [9:0]  pre_adr;
    logic [31:0] pre_dat;
    logic [31:0] mem [0:1023];

    int n_cmp;
    int n_err;

    ram_host_adapter #(
        .dat_width(32),
        .adr_width(32),
        .mem_size (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .host_req  (host_req),
        .host_ack  (host_ack),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_be   (host_be),
        .host_wdata(host_wdata),
        .host_resp (host_resp),
        .host_rdata(host_rdata),
        .ram_adr_o (ram_adr_o),
        .ram_dat_o (ram_dat_o),
        .ram_we_o  (ram_we_o),
        .ram_dat_i (ram_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, one-cycle read latency, plus a preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_adr] <= pre_dat;
        end else if (ram_we_o) begin
            mem[ram_adr_o[9:0]] <= ram_dat_o;
        end
        ram_dat_i <= mem[ram_adr_o[9:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        host_req   = req;
        host_we    = we;
        host_addr  = addr;
        host_be    = be;
        host_wdata = wd;
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        cyc();
        pre_we  = 1'b1;
        pre_adr = a;
        pre_dat = d;
        cyc();
        pre_we  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_wadr, input logic [31:0] exp);
        cyc();
        drive(1'b1, 1'b0, addr, 4'h0, 32'h0);
        chk({tag, "_ack"}, {31'd0, host_ack}, 32'd1);
        chk({tag, "_we"}, {31'd0, ram_we_o}, 32'd0);
        chk({tag, "_adr"}, ram_adr_o, exp_wadr);
        cyc();
        drive(1'b1, 1'b0, addr, 4'h0, 32'h0);
        chk({tag, "_noack_wait"}, {31'd0, host_ack}, 32'd0);
        chk({tag, "_resp_early"}, {31'd0, host_resp}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk({tag, "_resp"}, {31'd0, host_resp}, 32'd1);
        chk({tag, "_rdata"}, host_rdata, exp);
        cyc();
        chk({tag, "_resp_end"}, {31'd0, host_resp}, 32'd0);
        chk({tag, "_rdata_hold"}, host_rdata, exp);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        pre_we     = 1'b0;
        pre_adr    = 10'd0;
        pre_dat    = 32'h0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 32'h0;
        host_be    = 4'h0;
        host_wdata = 32'h0;

        // Reset: requests are ignored and nothing is written.
        cyc();
        cyc();
        drive(1'b1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        chk("rst_ack", {31'd0, host_ack}, 32'd0);
        chk("rst_we", {31'd0, ram_we_o}, 32'd0);
        chk("rst_resp", {31'd0, host_resp}, 32'd0);
        chk("rst_rdata", host_rdata, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        preload(10'd0, 32'hDEADBEEF);
        cyc();
        rst = 1'b0;

        // Plain read of word 0.
        do_read("rd0", 32'h0, 32'd0, 32'hDEADBEEF);

        // Full write to 0x10, then two back-to-back full writes, then read back.
        cyc();
        drive(1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678);
        chk("fw_ack", {31'd0, host_ack}, 32'd1);
        chk("fw_we", {31'd0, ram_we_o}, 32'd1);
        chk("fw_adr", ram_adr_o, 32'd4);
        chk("fw_dat", ram_dat_o, 32'h12345678);
        cyc();
        drive(1'b1, 1'b1, 32'h14, 4'hF, 32'h01020304);
        chk("fw2_ack", {31'd0, host_ack}, 32'd1);
        chk("fw2_adr", ram_adr_o, 32'd5);
        cyc();
        drive(1'b1, 1'b1, 32'h18, 4'hF, 32'h0A0B0C0D);
        chk("fw3_ack", {31'd0, host_ack}, 32'd1);
        chk("fw3_adr", ram_adr_o, 32'd6);
        do_read("rd10", 32'h10, 32'd4, 32'h12345678);
        do_read("rd14", 32'h14, 32'd5, 32'h01020304);

        // Partial write be=0x5 over 0xAABBCCDD.
        preload(10'd8, 32'hAABBCCDD);
        cyc();
        drive(1'b1, 1'b1, 32'h20, 4'h5, 32'h11223344);
        chk("pw_ack", {31'd0, host_ack}, 32'd1);
        chk("pw_rd_we", {31'd0, ram_we_o}, 32'd0);
        chk("pw_rd_adr", ram_adr_o, 32'd8);
        cyc();
        drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        chk("pw_rmw_noack", {31'd0, host_ack}, 32'd0);
        chk("pw_rmw_we", {31'd0, ram_we_o}, 32'd1);
        chk("pw_rmw_adr", ram_adr_o, 32'd8);
        chk("pw_rmw_dat", ram_dat_o, 32'hAA22CC44);
        do_read("rd20", 32'h20, 32'd8, 32'hAA22CC44);

        // Reset during RMW suppresses the write-back.
        preload(10'd12, 32'hAABBCCDD);
        cyc();
        drive(1'b1, 1'b1, 32'h30, 4'h5, 32'h11223344);
        chk("rmwrst_ack", {31'd0, host_ack}, 32'd1);
        cyc();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("rmwrst_we", {31'd0, ram_we_o}, 32'd0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        do_read("rd30", 32'h30, 32'd12, 32'hAABBCCDD);

        // Reset during RD_WAIT: no response pulse, back in IDLE next cycle.
        cyc();
        drive(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        chk("rdrst_ack", {31'd0, host_ack}, 32'd1);
        cyc();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("rdrst_resp_wait", {31'd0, host_resp}, 32'd0);
        cyc();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        chk("rdrst_noresp", {31'd0, host_resp}, 32'd0);
        chk("rdrst_rdata_clr", host_rdata, 32'h0);
        chk("rdrst_idle_ack", {31'd0, host_ack}, 32'd1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("rdrst2_resp_early", {31'd0, host_resp}, 32'd0);
        cyc();
        chk("rdrst2_resp", {31'd0, host_resp}, 32'd1);
        chk("rdrst2_rdata", host_rdata, 32'hAABBCCDD);

        // Write with be=0 leaves the word alone.
        preload(10'd16, 32'h55555555);
        cyc();
        drive(1'b1, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF);
        chk("be0_ack", {31'd0, host_ack}, 32'd1);
        chk("be0_we", {31'd0, ram_we_o}, 32'd0);
        do_read("rd40", 32'h40, 32'd16, 32'h55555555);

        // Address one past the end of the RAM.
        cyc();
        drive(1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
        chk("oor_ack", {31'd0, host_ack}, 32'd1);
`ifdef RAM_HOST_ADAPTER_RANGECHK_EN
        chk("oor_we", {31'd0, ram_we_o}, 32'd0);
        do_read("rd_oor", 32'h1000, 32'd1024, 32'h0);
        cyc();
        drive(1'b1, 1'b1, 32'h1000, 4'h3, 32'h0);
        chk("oor_pw_ack", {31'd0, host_ack}, 32'd1);
        chk("oor_pw_we", {31'd0, ram_we_o}, 32'd0);
        do_read("rd_w0", 32'h0, 32'd0, 32'hDEADBEEF);
`else
        chk("wrap_we", {31'd0, ram_we_o}, 32'd1);
        chk("wrap_adr", ram_adr_o, 32'd0);
        chk("wrap_dat", ram_dat_o, 32'hFFFFFFFF);
        do_read("rd_wrap", 32'h1000, 32'd0, 32'hFFFFFFFF);
        do_read("rd_w0", 32'h0, 32'd0, 32'hFFFFFFFF);
`endif

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
